noc_lookup_fabric: RTL and testbench
====================================

# noc_lookup_fabric

N-port request/response network for the page-value lookups exchanged between page-rank engines. Each engine port issues a page-id lookup; the fabric routes it to the owning port, fetches the value, and returns it to the requester together with the page id. This is the parametrised successor of the fixed 4-port request/response NoC wrapper, adding:
- configurable port count;
- per-destination round-robin arbitration;
- an owner stall input;
- per-request timeout and out-of-range error responses.

## Interface
Parameters:
- N, 4, number of ports (≥2).
- DATA_W, 16, page value width.
- PAGE_W, 7, global page id width.
- PAGES_PER_PORT, 16, pages owned per port; power of 2. LOCAL_W = log2(PAGES_PER_PORT). Owner = page >> LOCAL_W.
- TIMEOUT, 31, maximum cycles a pending request may wait ungranted (≥1).

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- req_valid, in, N: lookup request per port.
- req_page, in, N*PAGE_W: requested global page id. Port i occupies bits [i*PAGE_W +: PAGE_W].
- req_ready, out, N: port may accept a request (= !busy[i]).
- query_valid, out, N: lookup issued to owner port d.
- query_id, out, N*LOCAL_W: local page index at owner d.
- query_stall, in, N: owner d cannot accept a query this cycle.
- reply_data, in, N*DATA_W: owner d's value, valid exactly one cycle after query_valid[d].
- rsp_valid, out, N: one-cycle response pulse to requester i.
- rsp_data, out, N*DATA_W: returned value; 0 on error.
- rsp_page, out, N*PAGE_W: echo of the requested page id.
- rsp_err, out, N: 1 = timeout or out-of-range.

## Operation
- Handshake: a request is accepted when req_valid[i] & req_ready[i]. The fabric latches page and owner, and sets busy[i].
  - Each port has at most one outstanding request.
  - req_ready[i] stays low until the response pulse.
- Per-port states: IDLE → PEND → INFL → IDLE.
  - IDLE: nothing outstanding.
  - PEND: accepted, waiting for a grant.
  - INFL: granted, waiting for the owner's reply.
- Out-of-range: if page ≥ N*PAGES_PER_PORT at accept, go IDLE → ERR. Next cycle: rsp_valid=1, rsp_err=1, rsp_data=0. Then IDLE.
- Arbitration: one N-way round-robin arbiter per destination d.
  - Candidates are ports in PEND whose owner is d.
  - No grant while query_stall[d]=1.
  - Winner w drives query_valid[d]=1 and query_id[d]=page[w][LOCAL_W-1:0], records src[d]=w, and moves to INFL.
  - Pointer update: ptr[d] = (w+1) mod N, on grant only.
- Reply: in the cycle after a grant, reply_data[d] is registered into rsp_data[src[d]]. The port pulses rsp_valid and rsp_err=0, and returns to IDLE.
  - Each destination grants at most once per cycle and each port has one outstanding request, so responses never collide. No response arbitration is needed.
- Timeout: wait[i] counts cycles in PEND without a grant.
  - When wait[i]==TIMEOUT and there is no grant this cycle, respond with an error next cycle and go IDLE.
  - A grant in the same cycle wins over the timeout.
  - The counter clears on grant or accept.
- Self-lookup (owner == requester) is legal and arbitrated normally.

## Timing
- Reset values: all outputs 0 except req_ready, which is all ones. Arbiter pointers, src and counters are 0.
- Reset mid-operation: pending and in-flight requests are discarded, no responses are produced, and replies arriving in the next cycle are ignored.
- Latency for a request accepted in cycle T with no contention:
  - query_valid in T+1 (combinational from registered PEND state).
  - reply_data sampled at the end of T+2.
  - rsp_valid in T+3.
  - req_ready high in T+3, so back-to-back acceptance is possible in T+3.
- Out-of-range: rsp_valid in T+1.
- Timeout: a request accepted in T and never granted responds in T+1+TIMEOUT+1.

## Structure
- Shared package noc_pkg holds:
  - the port state enum (IDLE, PEND, INFL, ERR);
  - the LOCAL_W and owner-index width functions (clog2);
  - the error-response data constant (0).
- Sub-module noc_rr_arbiter: an N-way round-robin arbiter with request vector, enable, one-hot grant and an internal pointer. It is instantiated N times, once per destination.

## Test plan
- Single lookup: port 0 requests page 37 (owner 2, local 5), owner replies 0x1234 → query_valid[2] at T+1 with id 5; rsp_valid[0] at T+3 with data 0x1234, page 37, err 0.
- Contention: ports 0, 1 and 3 request pages 16, 17 and 18 in the same cycle → three grants on owner 1, in order 0, 1, 3 over consecutive cycles. A repeated burst starts after 3, with port 0 granted first.
- Stall and timeout: TIMEOUT=4, query_stall[1] held high, port 2 requests page 20 at T → rsp_valid[2] with err=1 and data 0 at T+6; no query_valid[1].
- Stall released on the timeout cycle → the grant wins: no error, normal response.
- Out-of-range: port 3 requests page 64 with N=4 → rsp_err at T+1, and req_ready[3] is high again at T+1.
- Reset asserted in the cycle after a grant → no rsp_valid afterwards, and all req_ready are high after reset.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and helpers for the page-value lookup fabric.
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        INFL = 2'd2,
        ERR  = 2'd3
    } port_state_t;

    // Width of the local page index inside one owner port.
    function automatic int local_w(input int pages_per_port);
        return $clog2(pages_per_port);
    endfunction

    // Width of a port/owner index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ERR_DATA = 0;

endpackage

// File: rtl/noc_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational; pointer moves to winner+1 on the clock edge of a grant.
// Backpressure: en=0 suppresses all grants and freezes the pointer.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/noc_lookup_fabric.sv
// N-port page-value lookup fabric: routes each port's page lookup to its owner and returns the value.
// Latency: accept T -> query T+1 -> reply sampled end of T+2 -> response T+3; out-of-range T+1.
// Backpressure: one outstanding request per port (req_ready low while pending); query_stall holds grants.
module noc_lookup_fabric
    import noc_pkg::*;
#(
    parameter  int N              = 4,
    parameter  int DATA_W         = 16,
    parameter  int PAGE_W         = 7,
    parameter  int PAGES_PER_PORT = 16,
    parameter  int TIMEOUT        = 31,
    localparam int LOCAL_W        = local_w(PAGES_PER_PORT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req_valid,
    input  logic [N*PAGE_W-1:0]   req_page,
    output logic [N-1:0]          req_ready,
    output logic [N-1:0]          query_valid,
    output logic [N*LOCAL_W-1:0]  query_id,
    input  logic [N-1:0]          query_stall,
    input  logic [N*DATA_W-1:0]   reply_data,
    output logic [N-1:0]          rsp_valid,
    output logic [N*DATA_W-1:0]   rsp_data,
    output logic [N*PAGE_W-1:0]   rsp_page,
    output logic [N-1:0]          rsp_err
);

    localparam int OW_W = idx_w(N);
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [PAGE_W-1:0] page;
        logic [OW_W-1:0]   owner;
    } req_rec_t;

    port_state_t       state_q [N];
    port_state_t       state_d [N];
    req_rec_t          rec_q   [N];
    logic [CW-1:0]     wait_q  [N];

    logic [PAGE_W-1:0] in_page  [N];
    logic [OW_W-1:0]   in_owner [N];
    logic [N-1:0]      in_oor;
    logic [N-1:0]      accept;
    logic [N-1:0]      granted;
    logic [N-1:0]      timeout_hit;

    logic [N-1:0]      cand    [N];
    logic [N-1:0]      gnt     [N];
    logic [OW_W-1:0]   gnt_idx [N];
    logic [N-1:0]      gnt_q;
    logic [OW_W-1:0]   src_q   [N];

    logic [N-1:0]      rsp_valid_q;
    logic [N-1:0]      rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q [N];
    logic [PAGE_W-1:0] rsp_page_q [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_port
            assign in_page[g]  = req_page[g*PAGE_W +: PAGE_W];
            assign in_owner[g] = OW_W'(in_page[g] >> LOCAL_W);
            assign in_oor[g]   = 32'(in_page[g]) >= 32'(N * PAGES_PER_PORT);
            assign accept[g]   = req_valid[g] & req_ready[g];

            assign rsp_data[g*DATA_W +: DATA_W] = rsp_data_q[g];
            assign rsp_page[g*PAGE_W +: PAGE_W] = rsp_page_q[g];
        end
    endgenerate

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

    // Destination d only sees ports that are pending on a page it owns.
    always_comb begin
        for (int d = 0; d < N; d++) begin
            cand[d] = '0;
            for (int i = 0; i < N; i++) begin
                cand[d][i] = (state_q[i] == PEND) && (rec_q[i].owner == OW_W'(d));
            end
        end
    end

    generate
        for (g = 0; g < N; g++) begin : g_dest
            noc_rr_arbiter #(.N(N)) u_arb (
                .clk     (clk),
                .reset   (reset),
                .req     (cand[g]),
                .en      (!query_stall[g]),
                .gnt     (gnt[g]),
                .gnt_idx (gnt_idx[g])
            );

            assign query_valid[g] = |gnt[g];
            assign query_id[g*LOCAL_W +: LOCAL_W] =
                query_valid[g] ? rec_q[gnt_idx[g]].page[LOCAL_W-1:0] : '0;
        end
    endgenerate

    always_comb begin
        granted = '0;
        for (int d = 0; d < N; d++) begin
            granted = granted | gnt[d];
        end
    end

    // A grant in the deadline cycle takes priority over the timeout.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            timeout_hit[i] = (state_q[i] == PEND) && (wait_q[i] == CW'(TIMEOUT)) && !granted[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE, ERR: begin
                    state_d[i] = IDLE;
                    if (accept[i]) state_d[i] = in_oor[i] ? ERR : PEND;
                end
                PEND: begin
                    if (granted[i])          state_d[i] = INFL;
                    else if (timeout_hit[i]) state_d[i] = IDLE;
                end
                INFL:    state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_ready[i] = (state_q[i] == IDLE) || (state_q[i] == ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            for (int i = 0; i < N; i++) begin
                rec_q[i]      <= '0;
                wait_q[i]     <= '0;
                src_q[i]      <= '0;
                rsp_data_q[i] <= '0;
                rsp_page_q[i] <= '0;
            end
        end else begin
            rsp_valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                if (accept[i]) begin
                    rec_q[i]  <= '{page: in_page[i], owner: in_owner[i]};
                    wait_q[i] <= '0;
                    if (in_oor[i]) begin
                        rsp_valid_q[i] <= 1'b1;
                        rsp_err_q[i]   <= 1'b1;
                        rsp_data_q[i]  <= DATA_W'(ERR_DATA);
                        rsp_page_q[i]  <= in_page[i];
                    end
                end else if (state_q[i] == PEND) begin
                    if (granted[i]) begin
                        wait_q[i] <= '0;
                    end else if (timeout_hit[i]) begin
                        rsp_valid_q[i] <= 1'b1;
                        rsp_err_q[i]   <= 1'b1;
                        rsp_data_q[i]  <= DATA_W'(ERR_DATA);
                        rsp_page_q[i]  <= rec_q[i].page;
                    end else begin
                        wait_q[i] <= wait_q[i] + CW'(1);
                    end
                end
            end
            // The reply lands one cycle after the grant; its requester is still INFL, so no collision.
            for (int d = 0; d < N; d++) begin
                gnt_q[d] <= query_valid[d];
                if (query_valid[d]) src_q[d] <= gnt_idx[d];
                if (gnt_q[d]) begin
                    rsp_valid_q[src_q[d]] <= 1'b1;
                    rsp_err_q[src_q[d]]   <= 1'b0;
                    rsp_data_q[src_q[d]]  <= reply_data[d*DATA_W +: DATA_W];
                    rsp_page_q[src_q[d]]  <= rec_q[src_q[d]].page;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_lookup_fabric.sv
// Scoreboard bench for noc_lookup_fabric: directed lookups, monitor checks queries and responses.
module tb_noc_lookup_fabric;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int PAGE_W = 7;
    localparam int PPP    = 16;
    localparam int TMO    = 4;
    localparam int LW     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         req_valid;
    logic [N*PAGE_W-1:0]  req_page;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         query_valid;
    logic [N*LW-1:0]      query_id;
    logic [N-1:0]         query_stall;
    logic [N*DATA_W-1:0]  reply_data;
    logic [N-1:0]         rsp_valid;
    logic [N*DATA_W-1:0]  rsp_data;
    logic [N*PAGE_W-1:0]  rsp_page;
    logic [N-1:0]         rsp_err;

    noc_lookup_fabric #(
        .N(N), .DATA_W(DATA_W), .PAGE_W(PAGE_W), .PAGES_PER_PORT(PPP), .TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_page    (req_page),
        .req_ready   (req_ready),
        .query_valid (query_valid),
        .query_id    (query_id),
        .query_stall (query_stall),
        .reply_data  (reply_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_page    (rsp_page),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct { int d; int id; int at; } qx_t;
    typedef struct { int p; int data; int page; int err; int at; } rx_t;
    qx_t qq[$];
    rx_t rq[$];

    logic [15:0] mem [N][PPP];
    logic        pend    [N];
    int          pend_id [N];

    // Owner model: value for a query appears during the following cycle.
    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            reply_data[d*DATA_W +: DATA_W] = pend[d] ? mem[d][pend_id[d]] : 16'hBAD0;
            pend[d]    = query_valid[d];
            pend_id[d] = int'(query_id[d*LW +: LW]);
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int d = 0; d < N; d++) begin
                if (query_valid[d]) begin
                    int k;
                    int gid;
                    k   = -1;
                    gid = int'(query_id[d*LW +: LW]);
                    for (int j = 0; j < qq.size(); j++) if (k < 0 && qq[j].d == d) k = j;
                    checks++;
                    if (k < 0) begin
                        errors++;
                        $display("FAIL query_unexpected dest=%0d got id=%0d cyc=%0d", d, gid, cyc);
                    end else begin
                        if (qq[k].id != gid || qq[k].at != cyc) begin
                            errors++;
                            $display("FAIL query dest=%0d got id=%0d cyc=%0d want id=%0d cyc=%0d",
                                     d, gid, cyc, qq[k].id, qq[k].at);
                        end
                        qq.delete(k);
                    end
                end
            end
            for (int p = 0; p < N; p++) begin
                if (rsp_valid[p]) begin
                    int k;
                    int gd;
                    int gp;
                    int ge;
                    k  = -1;
                    gd = int'(rsp_data[p*DATA_W +: DATA_W]);
                    gp = int'(rsp_page[p*PAGE_W +: PAGE_W]);
                    ge = int'(rsp_err[p]);
                    for (int j = 0; j < rq.size(); j++) if (k < 0 && rq[j].p == p) k = j;
                    checks++;
                    if (k < 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected port=%0d got data=%h page=%0d err=%0d cyc=%0d",
                                 p, gd, gp, ge, cyc);
                    end else begin
                        if (rq[k].data != gd || rq[k].page != gp || rq[k].err != ge || rq[k].at != cyc) begin
                            errors++;
                            $display("FAIL rsp port=%0d got data=%h page=%0d err=%0d cyc=%0d want data=%h page=%0d err=%0d cyc=%0d",
                                     p, gd, gp, ge, cyc, rq[k].data, rq[k].page, rq[k].err, rq[k].at);
                        end
                        rq.delete(k);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [N*PAGE_W-1:0] pk(input int p0, input int p1, input int p2, input int p3);
        return {7'(p3), 7'(p2), 7'(p1), 7'(p0)};
    endfunction

    task automatic exq(input int d, input int id, input int at);
        qx_t e;
        e.d = d; e.id = id; e.at = at;
        qq.push_back(e);
    endtask

    task automatic exr(input int p, input int data, input int page, input int err, input int at);
        rx_t e;
        e.p = p; e.data = data; e.page = page; e.err = err; e.at = at;
        rq.push_back(e);
    endtask

    // Presents one request cycle; returns the accept cycle and leaves time at T+1 (+1ns).
    task automatic send(input logic [N-1:0] mask, input logic [N*PAGE_W-1:0] pages, output int t);
        @(posedge clk); #1;
        chk("ready_before_send", 64'(req_ready & mask), 64'(mask));
        req_valid = mask;
        req_page  = pages;
        t = cyc;
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        reset       = 1'b1;
        req_valid   = '0;
        req_page    = '0;
        query_stall = '0;
        reply_data  = '0;
        for (int d = 0; d < N; d++) begin
            pend[d]    = 1'b0;
            pend_id[d] = 0;
            for (int k = 0; k < PPP; k++) mem[d][k] = 16'h0A00 | 16'(d << 4) | 16'(k);
        end
        mem[2][5] = 16'h1234;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_req_ready",   64'(req_ready),   64'hF);
        chk("reset_query_valid", 64'(query_valid), 64'h0);
        chk("reset_query_id",    64'(query_id),    64'h0);
        chk("reset_rsp_valid",   64'(rsp_valid),   64'h0);
        chk("reset_rsp_err",     64'(rsp_err),     64'h0);
        chk("reset_rsp_data",    64'(rsp_data),    64'h0);
        chk("reset_rsp_page",    64'(rsp_page),    64'h0);

        // Single lookup: page 37 -> owner 2, local 5.
        send(4'b0001, pk(37, 0, 0, 0), t);
        chk("busy_after_accept", 64'(req_ready[0]), 64'h0);
        exq(2, 5, t + 1);
        exr(0, 16'h1234, 37, 0, t + 3);
        idle(4);

        // Contention on owner 1: grants 0, 1, 3.
        send(4'b1011, pk(16, 17, 0, 18), t);
        exq(1, 0, t + 1); exq(1, 1, t + 2); exq(1, 2, t + 3);
        exr(0, 16'h0A10, 16, 0, t + 3);
        exr(1, 16'h0A11, 17, 0, t + 4);
        exr(3, 16'h0A12, 18, 0, t + 5);
        idle(6);

        // Repeated burst: pointer wrapped after port 3, so port 0 first again.
        send(4'b1011, pk(19, 21, 0, 22), t);
        exq(1, 3, t + 1); exq(1, 5, t + 2); exq(1, 6, t + 3);
        exr(0, 16'h0A13, 19, 0, t + 3);
        exr(1, 16'h0A15, 21, 0, t + 4);
        exr(3, 16'h0A16, 22, 0, t + 5);
        idle(6);

        // Lone grant to port 1 moves the pointer to 2; next burst order is 3, 0, 1.
        send(4'b0010, pk(0, 23, 0, 0), t);
        exq(1, 7, t + 1);
        exr(1, 16'h0A17, 23, 0, t + 3);
        idle(4);
        send(4'b1011, pk(24, 25, 0, 26), t);
        exq(1, 10, t + 1); exq(1, 8, t + 2); exq(1, 9, t + 3);
        exr(3, 16'h0A1A, 26, 0, t + 3);
        exr(0, 16'h0A18, 24, 0, t + 4);
        exr(1, 16'h0A19, 25, 0, t + 5);
        idle(6);

        // Stalled owner: timeout error at T+6, never queried.
        query_stall = 4'b0010;
        send(4'b0100, pk(0, 0, 20, 0), t);
        chk("busy_while_pend", 64'(req_ready[2]), 64'h0);
        exr(2, 0, 20, 1, t + 6);
        idle(6);
        query_stall = 4'b0000;
        idle(2);

        // Stall released exactly in the deadline cycle: grant wins.
        query_stall = 4'b0010;
        send(4'b0100, pk(0, 0, 21, 0), t);
        idle(4);
        query_stall = 4'b0000;
        exq(1, 5, t + 5);
        exr(2, 16'h0A15, 21, 0, t + 7);
        idle(5);

        // Out-of-range page: immediate error, port ready again next cycle.
        send(4'b1000, pk(0, 0, 0, 64), t);
        chk("oor_ready_next", 64'(req_ready[3]), 64'h1);
        exr(3, 0, 64, 1, t + 1);
        idle(3);

        // Reset in the cycle after a grant: no response may follow.
        send(4'b0001, pk(37, 0, 0, 0), t);
        exq(2, 5, t + 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("ready_after_reset", 64'(req_ready), 64'hF);
        idle(6);
        chk("idle_after_reset_rsp", 64'(rsp_valid), 64'h0);

        chk("query_queue_drained", 64'(qq.size()), 64'h0);
        chk("rsp_queue_drained",   64'(rq.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
